// File: rtl/ar_br_cr_pkg.sv
// Shared definitions for the AR/BR/CR controller-datapath and its dispatcher.
// Holds the FSM state encoding and default widths.
package ar_br_cr_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned JOBS_W     = 8;
  localparam int unsigned WD_W       = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } state_e;

endpackage

// File: rtl/operand_fifo.sv
// Circular-buffer FIFO of operand pairs; the head is always visible on head_c_o.
// The caller gates push with full and pop with empty.
module operand_fifo
  import ar_br_cr_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             head_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_c_o,
  output logic                     empty_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o  = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_c_o  = (count_q == CW'(DEPTH));
  assign empty_c_o = (count_q == '0);

endmodule

// File: rtl/ar_br_cr_dispatcher.sv
// Buffers AR/BR operand pairs and issues them one job at a time to the
// controller-datapath, tracking the busy handshake, completions and a watchdog.
module ar_br_cr_dispatcher
  import ar_br_cr_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_ar,
  input  logic [DATA_W-1:0]      in_br,
  output logic                   start,
  output logic [DATA_W-1:0]      AR_data,
  output logic [DATA_W-1:0]      BR_data,
  input  logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   done_pulse,
  output logic [JOBS_W-1:0]      jobs_done,
  output logic                   timeout_err
);

  localparam int unsigned PW = 2 * DATA_W;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ar_q, ar_d, br_q, br_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [JOBS_W-1:0]   jobs_q, jobs_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                push, pop, full, empty;
  logic [PW-1:0]       head;

  assign push = in_valid & ~full;

  operand_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   ({in_ar, in_br}),
    .head_c_o  (head),
    .count_o   (fifo_count),
    .full_c_o  (full),
    .empty_c_o (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ar_q    <= '0;
      br_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
      wd_q    <= wd_d;
    end
  end

  // start/done are computed one state ahead so they are registered pulses.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    jobs_d  = jobs_q;
    wd_d    = wd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          {ar_d, br_d} = head;
          pop          = 1'b1;
          start_d      = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy) begin
          state_d = WAIT_LO;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!busy) begin
          done_d  = 1'b1;
          jobs_d  = jobs_q + JOBS_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = ~full;
  assign start       = start_q;
  assign AR_data     = ar_q;
  assign BR_data     = br_q;
  assign done_pulse  = done_q;
  assign jobs_done   = jobs_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ar_br_cr_dispatcher.sv
// Scoreboard bench for ar_br_cr_dispatcher with a small behavioural model of the unit's busy handshake.
module tb_ar_br_cr_dispatcher;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_ar = '0;
  logic [DW-1:0] in_br = '0;
  logic          start;
  logic [DW-1:0] AR_data;
  logic [DW-1:0] BR_data;
  logic          busy = 1'b0;
  logic [2:0]    fifo_count;
  logic          done_pulse;
  logic [7:0]    jobs_done;
  logic          timeout_err;

  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_jobs = '0;
  logic [31:0] exp_q[$];
  int          bmode = 0;   // 0 normal unit, 1 busy held high, 2 never busy

  always #5 clk = ~clk;

  ar_br_cr_dispatcher #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ar(in_ar), .in_br(in_br), .start(start), .AR_data(AR_data),
    .BR_data(BR_data), .busy(busy), .fifo_count(fifo_count),
    .done_pulse(done_pulse), .jobs_done(jobs_done), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unit model: busy rises one cycle after it samples start, stays high 3 cycles.
  int   bcnt = 0;
  bit   arm = 1'b0;
  logic s_start;
  always @(posedge clk) begin
    s_start = start;
    #1;
    if (reset) begin
      arm = 1'b0; bcnt = 0; busy = 1'b0;
    end else if (bmode == 1) begin
      busy = 1'b1;
    end else if (bmode == 2) begin
      arm = 1'b0; bcnt = 0; busy = 1'b0;
    end else begin
      if (bcnt != 0) bcnt--;
      if (arm) begin arm = 1'b0; bcnt = 3; end
      if (s_start) arm = 1'b1;
      busy = (bcnt != 0);
    end
  end

  // Monitor: pops the expected operands on every start, tracks completions.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (start) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_start: got AR=%0h BR=%0h, expected no issue", AR_data, BR_data);
        end else begin
          e = exp_q.pop_front();
          check("issue_operands", {AR_data, BR_data}, e);
        end
      end
      if (done_pulse) begin
        done_cnt++;
        exp_jobs = exp_jobs + 8'd1;
        check("jobs_done_on_done", 32'(jobs_done), 32'(exp_jobs));
      end
    end
  end

  task automatic push(input logic [DW-1:0] ar, input logic [DW-1:0] br, input bit acc);
    check("in_ready_before_push", 32'(in_ready), 32'(acc));
    in_valid = 1'b1; in_ar = ar; in_br = br;
    if (acc) exp_q.push_back({ar, br});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int b = budget;
    while (done_cnt < target) begin
      if (b == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wait_jobs_timeout: got %0d completions, expected %0d", done_cnt, target);
        break;
      end
      @(posedge clk);
      b--;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_fifo_count"}, 32'(fifo_count), 0);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_AR_BR"}, {AR_data, BR_data}, 0);
    check({tag, "_done"}, 32'(done_pulse), 0);
    check({tag, "_jobs"}, 32'(jobs_done), 0);
    check({tag, "_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Single job: start one cycle after acceptance, operands held.
    push(16'h8004, 16'h0003, 1'b1);
    check("lat_count_k", 32'(fifo_count), 1);
    check("lat_start_k", 32'(start), 0);
    @(negedge clk);
    check("lat_start_k1", 32'(start), 1);
    check("single_AR", 32'(AR_data), 32'h8004);
    check("single_BR", 32'(BR_data), 32'h0003);
    wait_jobs(1, 100);
    check("single_done_one_cycle", 32'(done_pulse), 0);
    check("single_jobs", 32'(jobs_done), 1);
    check("single_hold_AR", 32'(AR_data), 32'h8004);

    // Fill and overflow while the unit is busy.
    bmode = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1);
    push(16'h1FFF, 16'h2FFF, 1'b0);
    check("full_count", 32'(fifo_count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    check("no_issue_while_busy", 32'(start), 0);
    bmode = 0;
    wait_jobs(5, 300);
    check("fill_jobs", 32'(jobs_done), 5);

    // Push on the same edge as a pop with two entries queued.
    bmode = 1;
    @(negedge clk);
    push(16'hA001, 16'hB001, 1'b1);
    push(16'hA002, 16'hB002, 1'b1);
    bmode = 0;
    @(negedge clk);
    check("pre_simul_count", 32'(fifo_count), 2);
    push(16'hA003, 16'hB003, 1'b1);
    check("simul_count", 32'(fifo_count), 2);
    check("simul_start", 32'(start), 1);
    wait_jobs(8, 300);
    check("simul_jobs", 32'(jobs_done), 8);

    // Watchdog: unit never acknowledges.
    bmode = 2;
    @(negedge clk);
    push(16'hDEAD, 16'hBEEF, 1'b1);
    @(negedge clk);
    check("wd_start", 32'(start), 1);
    repeat (TO) @(negedge clk);
    check("wd_err_before", 32'(timeout_err), 0);
    @(negedge clk);
    check("wd_err_set", 32'(timeout_err), 1);
    check("wd_no_done", 32'(done_cnt), 8);
    check("wd_jobs_unchanged", 32'(jobs_done), 8);
    bmode = 0;
    push(16'h0042, 16'h0007, 1'b1);
    wait_jobs(9, 100);
    check("wd_next_jobs", 32'(jobs_done), 9);
    check("wd_err_sticky", 32'(timeout_err), 1);

    // Reset while in WAIT_LO with two entries queued.
    push(16'hC001, 16'hD001, 1'b1);
    push(16'hC002, 16'hD002, 1'b1);
    push(16'hC003, 16'hD003, 1'b1);
    repeat (2) @(negedge clk);
    check("midjob_count", 32'(fifo_count), 2);
    check("midjob_busy_model", 32'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("midreset");
    exp_jobs = '0;
    reset = 1'b0;
    @(negedge clk);

    // Counter wrap over 256 completed jobs.
    base = done_cnt;
    for (int i = 0; i < 256; i++) begin
      push(16'(i), ~16'(i), 1'b1);
      wait_jobs(base + i + 1, 100);
    end
    check("wrap_jobs", 32'(jobs_done), 0);
    check("wrap_done_count", 32'(done_cnt - base), 256);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ar_br_cr_dispatcher.md
# ar_br_cr_dispatcher

Upstream feeder for the AR/BR/CR controller–datapath unit. It buffers incoming operand pairs in a small FIFO and issues them one at a time to the unit. Each issue is a one-cycle `start` pulse with `AR_data`/`BR_data` held stable. The dispatcher then tracks the unit's `busy` handshake to completion and counts finished jobs. A watchdog flags a unit that never acknowledges `start`.

## Interface
Parameters:
- `DATA_W`, default 16: operand width; must match the AR/BR datapath.
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `TIMEOUT`, default 15: maximum cycles in WAIT_HI before abort; 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: producer offers an operand pair.
- `in_ready` out 1: equals FIFO not full.
- `in_ar` in DATA_W: AR operand.
- `in_br` in DATA_W: BR operand.
- `start` out 1: one-cycle issue pulse to the unit.
- `AR_data` out DATA_W: registered AR operand to the unit.
- `BR_data` out DATA_W: registered BR operand to the unit.
- `busy` in 1: busy flag from the unit.
- `fifo_count` out clog2(DEPTH)+1: current occupancy.
- `done_pulse` out 1: one cycle per completed job.
- `jobs_done` out 8: completed-job counter; wraps 255→0.
- `timeout_err` out 1: sticky; set on watchdog expiry.

## Operation
- Push: when `in_valid && in_ready`, {in_ar, in_br} is written at the tail. Writes are ignored when full because `in_ready`=0.
- Pop: happens only on the IDLE→ISSUE transition. A push and pop on the same edge leaves `fifo_count` unchanged. Order is strictly FIFO.
- FSM states are IDLE, ISSUE, WAIT_HI and WAIT_LO.
  - IDLE: if `fifo_count`≠0 and `busy`=0, load the head into `AR_data`/`BR_data`, pop, and go to ISSUE. Otherwise stay.
  - ISSUE: `start`=1 for exactly this cycle. Clear the watchdog counter and go to WAIT_HI.
  - WAIT_HI: if `busy`=1, go to WAIT_LO. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT, set `timeout_err` and return to IDLE. The job is dropped, not counted, and not retried.
  - WAIT_LO: if `busy`=0, assert `done_pulse` for one cycle, increment `jobs_done`, and go to IDLE.
- `start`, `done_pulse` and `in_ready` are decoded from registered state, with no combinational path from `busy`/`in_valid`.
- `AR_data`/`BR_data` change only on IDLE→ISSUE. They hold their value through the whole job and afterwards.
- If `busy` is already 1 in IDLE (unit not idle), no issue occurs until it drops.
- `timeout_err` clears only on reset.
- `jobs_done` wraps 255→0 without a flag.

## Timing
- Reset values: state IDLE, FIFO empty, `fifo_count`=0, `in_ready`=1 (from the first cycle after reset). `start`=0, `AR_data`=`BR_data`=0, `done_pulse`=0, `jobs_done`=0, `timeout_err`=0.
- Issue latency: a pair accepted at edge k into an empty FIFO, with `busy`=0, gives IDLE→ISSUE at edge k+1. `start` is high in cycle k+1..k+2 and the unit samples it at edge k+2.
- Completion: `done_pulse` is high in the cycle after the edge where WAIT_LO sees `busy`=0.
- Minimum job spacing: 4 cycles (IDLE, ISSUE, WAIT_HI, WAIT_LO), plus the unit's busy duration.
- Reset asserted mid-job: the next edge returns to IDLE and flushes the FIFO, and `start` drops. Pending jobs are lost; the unit is reset by its own `reset`.

## Structure
- Shared package `ar_br_cr_pkg` holds the FSM state encoding (2-bit localparams IDLE=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3) and the `DATA_W` default. The controller–datapath top uses the same package.
- Sub-module `operand_fifo` (2·DATA_W wide, DEPTH entries, push/pop/count/full/empty) is instantiated once. The FSM, output registers and counters live in the top.

## Test plan
- Single job: push (0x8004, 0x0003); the unit model raises `busy` 1 cycle after `start` for 3 cycles. Expect `start` at k+1, `AR_data`=0x8004 and `BR_data`=0x0003, one `done_pulse`, and `jobs_done`=1.
- Fill/overflow: hold `busy`=1 and push 5 pairs with DEPTH=4. Expect `in_ready`=0 after 4 pushes, `fifo_count`=4, the 5th pair not stored, and issue order preserved once `busy` drops.
- Simultaneous push/pop: push on the same edge as IDLE→ISSUE with count=2. Expect `fifo_count` to stay 2.
- Watchdog: the unit model never raises `busy`. Expect `timeout_err`=1 exactly TIMEOUT cycles after entering WAIT_HI, no `done_pulse`, and the next job issuing normally.
- Reset mid-job: assert `reset` in WAIT_LO with 2 entries queued. Expect all outputs at reset values the next cycle and `fifo_count`=0.
- Wrap: run 256 jobs. Expect `jobs_done` to go 255→0 and 256 `done_pulse`s.
